// File: rtl/dircc_mem_arb_pkg.sv
// Shared constants for the node memory s2-port arbiter: populated range,
// out-of-range read data and sticky error bit positions.
package dircc_mem_arb_pkg;

    localparam int          MEM_WORDS_DEFAULT = 20480;
    localparam logic [15:0] OOR_READ_DATA     = 16'h0000;

    localparam int ERR_OOR = 0;
    localparam int ERR_RW  = 1;

endpackage

// File: rtl/dircc_rr_arbiter.sv
// Combinational round-robin grant: first active requester at or above ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module dircc_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] active_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               grant_any_o
);

    logic [NUM_REQ-1:0] rot;
    logic [IDX_W:0]     sum;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        sum         = '0;
        // Rotate so bit 0 of rot is the requester the pointer names.
        rot = NUM_REQ'({active_i, active_i} >> ptr_i);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any_o && rot[k]) begin
                grant_any_o = 1'b1;
                sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
                if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                    sum = sum - (IDX_W+1)'(NUM_REQ);
                end
                grant_idx_o = sum[IDX_W-1:0];
                grant_o     = NUM_REQ'(1) << sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dircc_node_mem_port2_arbiter.sv
// Shares the node RAM s2 port between NUM_REQ Avalon-MM requesters with a
// same-cycle round-robin grant, range guard and fixed 1-cycle read return.
module dircc_node_mem_port2_arbiter
    import dircc_mem_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16,
    parameter int BE_W      = 2,
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      freeze,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [NUM_REQ-1:0]        req_readdatavalid,
    output logic [DATA_W-1:0]         req_readdata,
    output logic                      req_rsp_err,
    output logic [ADDR_W-1:0]         mem_address2,
    output logic [BE_W-1:0]           mem_byteenable2,
    output logic [DATA_W-1:0]         mem_writedata2,
    output logic                      mem_chipselect2,
    output logic                      mem_write2,
    output logic                      mem_clken2,
    input  logic [DATA_W-1:0]         mem_readdata2,
    output logic [1:0]                err_sticky,
    input  logic                      err_clear
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] active;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;

    logic               g_rd;
    logic               g_wr;
    logic [ADDR_W-1:0]  g_addr;
    logic [DATA_W-1:0]  g_wd;
    logic [BE_W-1:0]    g_be;
    logic               g_oor;

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic [DATA_W-1:0]  wd_q, wd_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDX_W-1:0]   rsp_idx_q, rsp_idx_d;
    logic               rsp_oor_q, rsp_oor_d;
    logic [1:0]         err_q, err_d;
    logic [1:0]         err_set;

    assign active = (reset || freeze) ? '0 : (req_read | req_write);

    dircc_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .active_i    (active),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (gnt_idx),
        .grant_any_o (gnt_any)
    );

    assign req_waitrequest = ~grant;

    always_comb begin
        g_rd   = 1'b0;
        g_wr   = 1'b0;
        g_addr = '0;
        g_wd   = '0;
        g_be   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                g_rd   = g_rd   | req_read[i];
                g_wr   = g_wr   | req_write[i];
                g_addr = g_addr | req_address[i*ADDR_W +: ADDR_W];
                g_wd   = g_wd   | req_writedata[i*DATA_W +: DATA_W];
                g_be   = g_be   | req_byteenable[i*BE_W +: BE_W];
            end
        end
    end

    assign g_oor = (32'(g_addr) >= 32'(MEM_WORDS));

    // RAM sees the grant in the same cycle so its registered read data lines
    // up with the response stage one cycle later.
    assign mem_chipselect2 = gnt_any & ~g_oor;
    assign mem_write2      = gnt_any & g_wr & ~g_oor;
    assign mem_address2    = gnt_any ? g_addr : addr_q;
    assign mem_byteenable2 = gnt_any ? g_be   : be_q;
    assign mem_writedata2  = gnt_any ? g_wd   : wd_q;
    assign mem_clken2      = 1'b1;

    always_comb begin
        ptr_d  = ptr_q;
        addr_d = addr_q;
        be_d   = be_q;
        wd_d   = wd_q;
        if (gnt_any) begin
            ptr_d  = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
            addr_d = g_addr;
            be_d   = g_be;
            wd_d   = g_wd;
        end
        // A read that also carries a write is dropped; the write wins.
        rsp_valid_d = gnt_any & g_rd & ~g_wr;
        rsp_idx_d   = gnt_idx;
        rsp_oor_d   = g_oor;

        err_set          = '0;
        err_set[ERR_OOR] = gnt_any & g_oor;
        err_set[ERR_RW]  = gnt_any & g_rd & g_wr;
        err_d            = (err_clear ? 2'b00 : err_q) | err_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            wd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_oor_q   <= 1'b0;
            err_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wd_q        <= wd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_oor_q   <= rsp_oor_d;
            err_q       <= err_d;
        end
    end

    // Gating with reset discards a response still in flight when reset arrives.
    assign req_readdatavalid = (rsp_valid_q && !reset) ? (NUM_REQ'(1) << rsp_idx_q) : '0;
    assign req_readdata      = rsp_oor_q ? DATA_W'(OOR_READ_DATA) : mem_readdata2;
    assign req_rsp_err       = rsp_valid_q & rsp_oor_q & ~reset;
    assign err_sticky        = err_q;

endmodule

// File: tb/tb_dircc_node_mem_port2_arbiter.sv
// Scoreboard bench: directed scenarios plus randomized traffic against a
// transaction-level model of arbitration, memory contents and sticky errors.
module tb_dircc_node_mem_port2_arbiter;

    localparam int N  = 2;
    localparam int AW = 15;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int MW = 20480;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic freeze = 1'b0;
    logic err_clear = 1'b0;
    logic [N-1:0]    req_read = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_address = '0;
    logic [N*DW-1:0] req_writedata = '0;
    logic [N*BW-1:0] req_byteenable = '0;
    logic [N-1:0]    req_waitrequest;
    logic [N-1:0]    req_readdatavalid;
    logic [DW-1:0]   req_readdata;
    logic            req_rsp_err;
    logic [AW-1:0]   mem_address2;
    logic [BW-1:0]   mem_byteenable2;
    logic [DW-1:0]   mem_writedata2;
    logic            mem_chipselect2;
    logic            mem_write2;
    logic            mem_clken2;
    logic [DW-1:0]   mem_readdata2;
    logic [1:0]      err_sticky;

    always #5 clk = ~clk;

    dircc_node_mem_port2_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .freeze            (freeze),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_address       (req_address),
        .req_writedata     (req_writedata),
        .req_byteenable    (req_byteenable),
        .req_waitrequest   (req_waitrequest),
        .req_readdatavalid (req_readdatavalid),
        .req_readdata      (req_readdata),
        .req_rsp_err       (req_rsp_err),
        .mem_address2      (mem_address2),
        .mem_byteenable2   (mem_byteenable2),
        .mem_writedata2    (mem_writedata2),
        .mem_chipselect2   (mem_chipselect2),
        .mem_write2        (mem_write2),
        .mem_clken2        (mem_clken2),
        .mem_readdata2     (mem_readdata2),
        .err_sticky        (err_sticky),
        .err_clear         (err_clear)
    );

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] be;
    } req_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        logic          err;
        int            cyc;
    } rsp_t;

    req_t pq0[$];
    req_t pq1[$];
    req_t cur [N];
    rsp_t sb[$];
    logic [N-1:0] acc = '0;
    int n_checks = 0;
    int n_errors = 0;
    int grant_cnt = 0;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {a[7:0] ^ 8'h5A, a[14:7] ^ 8'hC3};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        if (be[0]) r[7:0]  = d[7:0];
        if (be[1]) r[15:8] = d[15:8];
        return r;
    endfunction

    function automatic req_t mk(input logic rd, input logic wr, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [BW-1:0] be);
        req_t r;
        r.rd = rd; r.wr = wr; r.a = a; r.d = d; r.be = be;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM s2 behaviour: registered read, byte-enabled write.
    logic [DW-1:0] ram    [0:32767];
    logic          ram_wr [0:32767];
    always @(posedge clk) begin
        if (mem_chipselect2 && mem_clken2) begin
            if (mem_write2) begin
                ram[mem_address2]    <= merge(ram_wr[mem_address2] === 1'b1 ? ram[mem_address2]
                                              : init_word(mem_address2), mem_writedata2, mem_byteenable2);
                ram_wr[mem_address2] <= 1'b1;
            end else begin
                mem_readdata2 <= (ram_wr[mem_address2] === 1'b1) ? ram[mem_address2]
                                 : init_word(mem_address2);
            end
        end
    end

    // Reference memory, updated from the requests the model grants.
    logic [DW-1:0] ref_mem [0:32767];
    logic          ref_wr  [0:32767];

    // Driver: replace a requester's request after it was accepted or when idle.
    initial begin : drv
        for (int i = 0; i < N; i++) cur[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] || (!cur[i].rd && !cur[i].wr)) begin
                    cur[i] = '0;
                    if (i == 0 && pq0.size() > 0) cur[i] = pq0.pop_front();
                    if (i == 1 && pq1.size() > 0) cur[i] = pq1.pop_front();
                end
                req_read[i]                = cur[i].rd;
                req_write[i]               = cur[i].wr;
                req_address[i*AW +: AW]    = cur[i].a;
                req_writedata[i*DW +: DW]  = cur[i].d;
                req_byteenable[i*BW +: BW] = cur[i].be;
            end
        end
    end

    // Engine: predicts the grant of the coming edge and its effects.
    initial begin : eng
        int g, j, cyc, ptr_m;
        logic [1:0] err_m, eset;
        logic [N-1:0] ew;
        logic oor;
        req_t r;
        ptr_m = 0;
        err_m = 2'b00;
        forever begin
            @(negedge clk);
            cyc = int'($time / 10);
            g = -1;
            if (!reset && !freeze) begin
                for (int k = 0; k < N; k++) begin
                    j = (ptr_m + k) % N;
                    if (g < 0 && (cur[j].rd || cur[j].wr)) g = j;
                end
            end
            ew = '1;
            if (g >= 0) ew[g] = 1'b0;
            chk("waitrequest", 32'(req_waitrequest), 32'(ew));
            acc  = '0;
            eset = 2'b00;
            if (g >= 0) begin
                r   = cur[g];
                oor = (32'(r.a) >= 32'(MW));
                chk("chipselect", 32'(mem_chipselect2), 32'(!oor));
                if (!oor) begin
                    chk("mem_write", 32'(mem_write2), 32'(r.wr));
                    chk("mem_addr", 32'(mem_address2), 32'(r.a));
                    if (r.wr) begin
                        chk("mem_wdata", 32'(mem_writedata2), 32'(r.d));
                        chk("mem_be", 32'(mem_byteenable2), 32'(r.be));
                        ref_mem[r.a] = merge(ref_wr[r.a] === 1'b1 ? ref_mem[r.a] : init_word(r.a),
                                             r.d, r.be);
                        ref_wr[r.a]  = 1'b1;
                    end
                end
                if (r.rd && !r.wr) begin
                    sb.push_back('{idx: g,
                                   data: oor ? 16'h0000 :
                                         (ref_wr[r.a] === 1'b1 ? ref_mem[r.a] : init_word(r.a)),
                                   err: oor, cyc: cyc});
                end
                if (oor) eset[0] = 1'b1;
                if (r.rd && r.wr) eset[1] = 1'b1;
                ptr_m  = (g + 1) % N;
                acc[g] = 1'b1;
                grant_cnt++;
            end else begin
                chk("idle_cs", 32'(mem_chipselect2), 32'd0);
                chk("idle_wr", 32'(mem_write2), 32'd0);
            end
            chk("err_sticky", 32'(err_sticky), 32'(err_m));
            if (reset) begin
                err_m = 2'b00;
                ptr_m = 0;
            end else begin
                err_m = (err_clear ? 2'b00 : err_m) | eset;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    initial begin : mon
        int cyc;
        rsp_t e;
        forever begin
            @(negedge clk);
            cyc = int'($time / 10);
            if (reset) begin
                chk("rdv_in_reset", 32'(req_readdatavalid), 32'd0);
            end else if (|req_readdatavalid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rsp: got valid %b expected none at %0t",
                             req_readdatavalid, $time);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_onehot", 32'(req_readdatavalid), 32'(1) << e.idx);
                    chk("rsp_data", 32'(req_readdata), 32'(e.data));
                    chk("rsp_err", 32'(req_rsp_err), 32'(e.err));
                    chk("rsp_latency", 32'(cyc - e.cyc), 32'd1);
                end
            end else begin
                chk("rsp_err_idle", 32'(req_rsp_err), 32'd0);
                if (sb.size() > 0 && sb[0].cyc < cyc) begin
                    e = sb.pop_front();
                    n_checks++;
                    n_errors++;
                    $display("FAIL missing_rsp: got no valid expected req %0d data %h at %0t",
                             e.idx, e.data, $time);
                end
            end
        end
    end

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((pq0.size() > 0 || pq1.size() > 0 || cur[0].rd || cur[0].wr ||
                cur[1].rd || cur[1].wr || sb.size() > 0) && t < 2000) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        if (t >= 2000) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_%s: got timeout expected idle", name);
        end
    endtask

    task automatic wait_grant(input int g0);
        int t;
        t = 0;
        while (grant_cnt == g0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_grant: got no grant expected one");
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int g0, kind;
        logic [AW-1:0] a;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        for (int k = 0; k < 4; k++) begin
            pq0.push_back(mk(1'b1, 1'b0, 15'h0010, 16'h0, 2'b00));
            pq1.push_back(mk(1'b1, 1'b0, 15'h0020, 16'h0, 2'b00));
        end
        drain("alternate");

        pq1.push_back(mk(1'b0, 1'b1, 15'h0100, 16'hBEEF, 2'b10));
        drain("write_be");
        pq0.push_back(mk(1'b1, 1'b0, 15'h0100, 16'h0, 2'b00));
        drain("read_be");

        pq0.push_back(mk(1'b1, 1'b0, 15'h5000, 16'h0, 2'b00));
        drain("oor");
        chk("oor_sticky", 32'(err_sticky), 32'd1);
        err_clear = 1'b1;
        @(posedge clk);
        #1 err_clear = 1'b0;
        chk("oor_cleared", 32'(err_sticky), 32'd0);

        g0 = grant_cnt;
        pq0.push_back(mk(1'b1, 1'b0, 15'h0011, 16'h0, 2'b00));
        pq0.push_back(mk(1'b1, 1'b0, 15'h0012, 16'h0, 2'b00));
        wait_grant(g0);
        @(posedge clk);
        #1 freeze = 1'b1;
        repeat (4) @(posedge clk);
        #1 freeze = 1'b0;
        drain("freeze");

        g0 = grant_cnt;
        pq0.push_back(mk(1'b1, 1'b0, 15'h0030, 16'h0, 2'b00));
        wait_grant(g0);
        @(posedge clk);
        #1 reset = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        drain("reset");

        pq0.push_back(mk(1'b1, 1'b1, 15'h0004, 16'h1234, 2'b11));
        drain("rw_both");
        chk("rw_sticky", 32'(err_sticky), 32'd2);
        pq0.push_back(mk(1'b1, 1'b0, 15'h0004, 16'h0, 2'b00));
        drain("rw_readback");

        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 150; k++) begin
                kind = int'($urandom_range(0, 9));
                a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(MW, 32767))
                                                : AW'($urandom_range(0, 63));
                if (i == 0)
                    pq0.push_back(mk(kind >= 2 && (kind <= 5 || kind == 9), kind >= 6, a,
                                     DW'($urandom), BW'($urandom)));
                else
                    pq1.push_back(mk(kind >= 2 && (kind <= 5 || kind == 9), kind >= 6, a,
                                     DW'($urandom), BW'($urandom)));
            end
        end
        for (int t = 0; t < 5000 && (pq0.size() > 0 || pq1.size() > 0); t++) begin
            @(posedge clk);
            #1;
            freeze    = ($urandom_range(0, 7) == 0);
            err_clear = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk);
        #1;
        freeze    = 1'b0;
        err_clear = 1'b0;
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
